// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer and its environment
// (hazard unit, EX-stage branch resolution, instruction memory).
interface pc_sequencer_if #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 16
);
    logic              stall;
    logic              imem_ready;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              trap_req;
    logic [PC_W-1:0]   trap_vector;
    logic [PC_W-1:0]   pc;
    logic              pc_valid;
    logic              flush;
    logic [CNT_W-1:0]  redirect_cnt;

    modport master (
        output stall, imem_ready, br_taken, br_target, trap_req, trap_vector,
        input  pc, pc_valid, flush, redirect_cnt
    );

    modport slave (
        input  stall, imem_ready, br_taken, br_target, trap_req, trap_vector,
        output pc, pc_valid, flush, redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: picks reset / trap / branch / hold / increment
// each cycle, raises a one-cycle flush on redirects and counts them.
module pc_sequencer #(
    parameter int              PC_W         = 64,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter int              PC_INC       = 4,
    parameter int              CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

    typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

    state_t            state;
    logic [PC_W-1:0]   pc_q;
    logic              valid_q;
    logic              flush_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PC_W-1:0]   target;

    // Trap has priority over branch; targets are word-aligned before loading.
    always_comb begin
        target = bus.trap_req ? bus.trap_vector : bus.br_target;
        target[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                BOOT, REDIRECT: begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                    flush_q <= 1'b0;
                end
                RUN: begin
                    if (bus.trap_req || bus.br_taken) begin
                        state   <= REDIRECT;
                        pc_q    <= target;
                        valid_q <= 1'b0;
                        flush_q <= 1'b1;
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + 1'b1;
                    end else if (!bus.stall && bus.imem_ready) begin
                        pc_q <= pc_q + INC;
                    end
                end
                default: begin
                    state   <= BOOT;
                    valid_q <= 1'b0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_valid     = valid_q;
    assign bus.flush        = flush_q;
    assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus randomized traffic, checked every cycle against an
// output-level model of the fetch PC rules.
module tb_pc_sequencer;
    localparam int PC_W  = 64;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .RESET_VECTOR('0), .PC_INC(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 0;

    // Model: a redirect is only accepted while the sequencer is issuing real
    // fetches; any bubble cycle is followed by a valid fetch at the held pc.
    logic [63:0] m_pc;
    bit          m_valid, m_flush;
    int          m_cnt;

    always @(posedge clk) begin
        if (!reset) begin
            m_pc = 64'h0; m_valid = 0; m_flush = 0; m_cnt = 0;
        end else if (!m_valid) begin
            m_valid = 1; m_flush = 0;
        end else if (bus.trap_req || bus.br_taken) begin
            m_pc    = (bus.trap_req ? bus.trap_vector : bus.br_target) & ~64'h3;
            m_valid = 0;
            m_flush = 1;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        end else if (!bus.stall && bus.imem_ready) begin
            m_pc = m_pc + 64'd4;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("pc",       bus.pc,                m_pc);
            chk("pc_valid", 64'(bus.pc_valid),     64'(m_valid));
            chk("flush",    64'(bus.flush),        64'(m_flush));
            chk("cnt",      64'(bus.redirect_cnt), 64'(m_cnt));
        end
    end

    // Literal expectations pin both the DUT and the model.
    task automatic pin(input string name, input logic [63:0] pc, input bit v, input bit f, input int c);
        chk({name, ".pc"},     bus.pc, pc);
        chk({name, ".m_pc"},   m_pc, pc);
        chk({name, ".valid"},  64'(bus.pc_valid), 64'(v));
        chk({name, ".m_valid"},64'(m_valid), 64'(v));
        chk({name, ".flush"},  64'(bus.flush), 64'(f));
        chk({name, ".cnt"},    64'(bus.redirect_cnt), 64'(c));
        chk({name, ".m_cnt"},  64'(m_cnt), 64'(c));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.stall = 0; bus.imem_ready = 1; bus.br_taken = 0; bus.trap_req = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0;
        bus.br_target = '0; bus.trap_vector = '0;
        idle();
        // 1: reset, boot bubble, sequential fetch
        cyc(); check_en = 1; cyc();
        pin("rst", 64'h0, 0, 0, 0);
        reset = 1;
        cyc(); pin("boot", 64'h0, 1, 0, 0);
        cyc(); pin("seq4", 64'h4, 1, 0, 0);
        cyc(); pin("seq8", 64'h8, 1, 0, 0);
        cyc(); cyc(); pin("at10", 64'h10, 1, 0, 0);
        // 2: branch with misaligned target
        bus.br_taken = 1; bus.br_target = 64'h103;
        cyc(); pin("br", 64'h100, 0, 1, 1);
        bus.br_taken = 0;
        cyc(); pin("br_hold", 64'h100, 1, 0, 1);
        cyc(); pin("br_inc", 64'h104, 1, 0, 1);
        // 3: trap beats branch; branch during REDIRECT ignored
        bus.trap_req = 1; bus.trap_vector = 64'h800; bus.br_taken = 1; bus.br_target = 64'h200;
        cyc(); pin("trap", 64'h800, 0, 1, 2);
        bus.trap_req = 0;
        cyc(); pin("trap_ign", 64'h800, 1, 0, 2);
        bus.br_taken = 0;
        cyc(); pin("trap_inc", 64'h804, 1, 0, 2);
        // 4: stall then imem not ready
        bus.br_taken = 1; bus.br_target = 64'h20;
        cyc(); bus.br_taken = 0;
        cyc(); pin("at20", 64'h20, 1, 0, 3);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin cyc(); pin("stall", 64'h20, 1, 0, 3); end
        bus.stall = 0; bus.imem_ready = 0;
        for (int i = 0; i < 2; i++) begin cyc(); pin("nrdy", 64'h20, 1, 0, 3); end
        bus.imem_ready = 1;
        cyc(); pin("resume", 64'h24, 1, 0, 3);
        // 5: wrap
        bus.br_taken = 1; bus.br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc(); bus.br_taken = 0;
        cyc(); pin("top", 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 4);
        cyc(); pin("wrap", 64'h0, 1, 0, 4);
        // 6: reset during REDIRECT, then counter saturation
        bus.br_taken = 1; bus.br_target = 64'h400;
        cyc(); pin("pre_rst", 64'h400, 0, 1, 5);
        bus.br_taken = 0; reset = 0;
        cyc(); pin("rst_redir", 64'h0, 0, 0, 0);
        reset = 1;
        cyc();
        for (int i = 1; i <= 20; i++) begin
            bus.br_taken = 1; bus.br_target = 64'(i * 16);
            cyc(); bus.br_taken = 0;
            cyc();
        end
        pin("sat", 64'd320, 1, 0, CMAX);
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset          = ($urandom_range(63) != 0);
            bus.stall      = ($urandom_range(3) == 0);
            bus.imem_ready = ($urandom_range(4) != 0);
            bus.br_taken   = ($urandom_range(5) == 0);
            bus.trap_req   = ($urandom_range(9) == 0);
            bus.br_target  = {$urandom, $urandom};
            bus.trap_vector = {$urandom, $urandom};
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
